// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply tile datapath: command op-codes,
// default geometry and the scheduler state encoding.
package matmul_pkg;

    localparam int TILE_DEF  = 4;
    localparam int DIM_W_DEF = 8;

    localparam logic [1:0] CMD_LOAD_A = 2'd0;
    localparam logic [1:0] CMD_LOAD_B = 2'd1;
    localparam logic [1:0] CMD_MAC    = 2'd2;
    localparam logic [1:0] CMD_STORE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CHECK       = 3'd1,
        ST_ISSUE_A     = 3'd2,
        ST_ISSUE_B     = 3'd3,
        ST_ISSUE_MAC   = 3'd4,
        ST_ISSUE_STORE = 3'd5,
        ST_DONE        = 3'd6,
        ST_ERR         = 3'd7
    } state_e;

endpackage

// File: rtl/tile_counter.sv
// Nested tile-index counter: k innermost, then j, then i. Each advance steps
// k; a k wrap carries into j, a j wrap carries into i.
module tile_counter
    import matmul_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [DIM_W-1:0] i_n_i,
    input  logic [DIM_W-1:0] i_n_j,
    input  logic [DIM_W-1:0] i_n_k,
    output logic [DIM_W-1:0] o_ti,
    output logic [DIM_W-1:0] o_tj,
    output logic [DIM_W-1:0] o_tk,
    output logic             o_last_k,
    output logic             o_last_tile
);

    logic [DIM_W-1:0] r_ti, r_tj, r_tk;
    logic             w_last_i, w_last_j, w_last_k;

    assign w_last_i = (r_ti == i_n_i - 1'b1);
    assign w_last_j = (r_tj == i_n_j - 1'b1);
    assign w_last_k = (r_tk == i_n_k - 1'b1);

    // Step the (i, j, k) triple with carries from k into j into i.
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ti <= '0;
            r_tj <= '0;
            r_tk <= '0;
        end else if (i_clear) begin
            r_ti <= '0;
            r_tj <= '0;
            r_tk <= '0;
        end else if (i_advance) begin
            if (!w_last_k) begin
                r_tk <= r_tk + 1'b1;
            end else begin
                r_tk <= '0;
                if (!w_last_j) begin
                    r_tj <= r_tj + 1'b1;
                end else begin
                    r_tj <= '0;
                    r_ti <= w_last_i ? '0 : r_ti + 1'b1;
                end
            end
        end
    end

    assign o_ti        = r_ti;
    assign o_tj        = r_tj;
    assign o_tk        = r_tk;
    assign o_last_k    = w_last_k;
    assign o_last_tile = w_last_i && w_last_j && w_last_k;

endmodule

// File: rtl/tile_scheduler.sv
// Tile command sequencer for C = A x B. Latches the dimensions on start,
// validates them, then streams LOAD_A/LOAD_B/MAC per k step and a STORE per
// (i, j) tile over a valid/ready handshake.
// Optional: define TILE_SCHED_PERF_EN to add busy/stall cycle counters.
module tile_scheduler
    import matmul_pkg::*;
#(
    parameter int TILE  = TILE_DEF,
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DIM_W-1:0] a_rows,
    input  logic [DIM_W-1:0] a_cols,
    input  logic [DIM_W-1:0] b_rows,
    input  logic [DIM_W-1:0] b_cols,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic [DIM_W-1:0] cmd_row,
    output logic [DIM_W-1:0] cmd_col,
    output logic             cmd_first,
    output logic             cmd_last,
    output logic             busy,
    output logic             done,
`ifdef TILE_SCHED_PERF_EN
    output logic [31:0]      perf_busy_cycles,
    output logic [31:0]      perf_stall_cycles,
`endif
    output logic             error
);

    localparam int LOG2_TILE = $clog2(TILE);

    state_e           r_state, w_next;
    logic [DIM_W-1:0] r_a_rows, r_a_cols, r_b_rows, r_b_cols;
    logic [DIM_W-1:0] r_n_i, r_n_j, r_n_k;
    logic [DIM_W-1:0] w_ti, w_tj, w_tk;
    logic [DIM_W-1:0] w_ti_off, w_tj_off, w_tk_off;
    logic             w_last_k, w_last_tile;
    logic             w_clear, w_advance, w_xfer, w_dim_err, w_start;

    // Tile count computed one bit wider so a dimension of 2^DIM_W-1 cannot wrap.
    function automatic logic [DIM_W-1:0] ceil_tiles(input logic [DIM_W-1:0] n);
        logic [DIM_W:0] sum;
        sum = {1'b0, n} + (DIM_W+1)'(TILE - 1);
        return DIM_W'(sum >> LOG2_TILE);
    endfunction

    assign w_start   = (r_state == ST_IDLE) && start;
    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_dim_err = (r_a_cols != r_b_rows) || (r_a_rows == '0) || (r_a_cols == '0)
                    || (r_b_rows == '0) || (r_b_cols == '0);

    // Capture the job dimensions on the accepted start edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_a_rows <= '0;
            r_a_cols <= '0;
            r_b_rows <= '0;
            r_b_cols <= '0;
        end else if (w_start) begin
            r_a_rows <= a_rows;
            r_a_cols <= a_cols;
            r_b_rows <= b_rows;
            r_b_cols <= b_cols;
        end
    end

    // Derive the tile loop bounds during the single CHECK cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_n_i <= '0;
            r_n_j <= '0;
            r_n_k <= '0;
        end else if (r_state == ST_CHECK) begin
            r_n_i <= ceil_tiles(r_a_rows);
            r_n_j <= ceil_tiles(r_b_cols);
            r_n_k <= ceil_tiles(r_a_cols);
        end
    end

    tile_counter #(.DIM_W(DIM_W)) u_counter (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_advance   (w_advance),
        .i_n_i       (r_n_i),
        .i_n_j       (r_n_j),
        .i_n_k       (r_n_k),
        .o_ti        (w_ti),
        .o_tj        (w_tj),
        .o_tk        (w_tk),
        .o_last_k    (w_last_k),
        .o_last_tile (w_last_tile)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and counter control; issue states only move on a transfer.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            ST_IDLE:      if (start) w_next = ST_CHECK;
            ST_CHECK: begin
                w_clear = 1'b1;
                w_next  = w_dim_err ? ST_ERR : ST_ISSUE_A;
            end
            ST_ISSUE_A:   if (w_xfer) w_next = ST_ISSUE_B;
            ST_ISSUE_B:   if (w_xfer) w_next = ST_ISSUE_MAC;
            ST_ISSUE_MAC: begin
                if (w_xfer) begin
                    if (w_last_k) begin
                        w_next = ST_ISSUE_STORE;
                    end else begin
                        w_advance = 1'b1;
                        w_next    = ST_ISSUE_A;
                    end
                end
            end
            ST_ISSUE_STORE: begin
                if (w_xfer) begin
                    w_advance = 1'b1;
                    w_next    = w_last_tile ? ST_DONE : ST_ISSUE_A;
                end
            end
            ST_DONE:      w_next = ST_IDLE;
            ST_ERR:       w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    assign w_ti_off = w_ti << LOG2_TILE;
    assign w_tj_off = w_tj << LOG2_TILE;
    assign w_tk_off = w_tk << LOG2_TILE;

    // Command fields decode from registered state and indices, so they are
    // stable for as long as the state holds waiting on cmd_ready.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = CMD_LOAD_A;
        cmd_row   = '0;
        cmd_col   = '0;
        cmd_first = 1'b0;
        cmd_last  = 1'b0;
        case (r_state)
            ST_ISSUE_A: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_LOAD_A;
                cmd_row   = w_ti_off;
                cmd_col   = w_tk_off;
            end
            ST_ISSUE_B: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_LOAD_B;
                cmd_row   = w_tk_off;
                cmd_col   = w_tj_off;
            end
            ST_ISSUE_MAC: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_MAC;
                cmd_row   = w_ti_off;
                cmd_col   = w_tj_off;
                cmd_first = (w_tk == '0);
                cmd_last  = w_last_k;
            end
            ST_ISSUE_STORE: begin
                cmd_valid = 1'b1;
                cmd_op    = CMD_STORE;
                cmd_row   = w_ti_off;
                cmd_col   = w_tj_off;
            end
            default: ;
        endcase
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign error = (r_state == ST_ERR);

`ifdef TILE_SCHED_PERF_EN
    logic [31:0] r_perf_busy, r_perf_stall;

    // Saturating job counters, cleared on reset and on each accepted start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_start) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else begin
            if (busy && (r_perf_busy != '1))
                r_perf_busy <= r_perf_busy + 1'b1;
            if (cmd_valid && !cmd_ready && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    assign perf_busy_cycles  = r_perf_busy;
    assign perf_stall_cycles = r_perf_stall;
`endif

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed bench for tile_scheduler: a reference loop nest pushes the expected
// command stream into a queue, each handshake transfer pops and compares.
`timescale 1ns/1ps
module tb_tile_scheduler;
    import matmul_pkg::*;

    localparam int RM_READY  = 0;
    localparam int RM_RANDOM = 1;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] row;
        logic [7:0] col;
        logic       first;
        logic       last;
    } cmd_t;

    logic       clock = 1'b0;
    logic       reset, start, cmd_ready;
    logic [7:0] a_rows, a_cols, b_rows, b_cols;
    logic       cmd_valid, cmd_first, cmd_last, busy, done, error;
    logic [1:0] cmd_op;
    logic [7:0] cmd_row, cmd_col;
`ifdef TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

    cmd_t exp_q[$];
    cmd_t last_cmd;
    int   checks = 0;
    int   errors = 0;

    initial forever #5 clock = ~clock;

    tile_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .a_rows    (a_rows),
        .a_cols    (a_cols),
        .b_rows    (b_rows),
        .b_cols    (b_cols),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_first (cmd_first),
        .cmd_last  (cmd_last),
        .busy      (busy),
        .done      (done),
`ifdef TILE_SCHED_PERF_EN
        .perf_busy_cycles  (perf_busy_cycles),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .error     (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference loop nest: i outer, j, k inner; returns whether the job should error.
    task automatic push_model(input int ar, input int ac, input int br, input int bc,
                              output logic exp_err);
        int ni, nj, nk;
        exp_q.delete();
        exp_err = (ac != br) || (ar == 0) || (ac == 0) || (br == 0) || (bc == 0);
        if (!exp_err) begin
            ni = (ar + 3) / 4;
            nj = (bc + 3) / 4;
            nk = (ac + 3) / 4;
            for (int i = 0; i < ni; i++) begin
                for (int j = 0; j < nj; j++) begin
                    for (int k = 0; k < nk; k++) begin
                        exp_q.push_back(cmd_t'{CMD_LOAD_A, 8'(i*4), 8'(k*4), 1'b0, 1'b0});
                        exp_q.push_back(cmd_t'{CMD_LOAD_B, 8'(k*4), 8'(j*4), 1'b0, 1'b0});
                        exp_q.push_back(cmd_t'{CMD_MAC, 8'(i*4), 8'(j*4), k == 0, k == nk-1});
                    end
                    exp_q.push_back(cmd_t'{CMD_STORE, 8'(i*4), 8'(j*4), 1'b0, 1'b0});
                end
            end
        end
    endtask

    // Start a job and drive/monitor it at falling edges until done, abort or budget.
    task automatic run_job(input int ar, input int ac, input int br, input int bc,
                           input int rmode, input int stall_idx, input int abort_after,
                           input int budget);
        logic exp_err, holding, got_done;
        cmd_t cur, held, exp;
        int   cyc, seq, stall_left;
        push_model(ar, ac, br, bc, exp_err);
        @(negedge clock);
        a_rows = 8'(ar);
        a_cols = 8'(ac);
        b_rows = 8'(br);
        b_cols = 8'(bc);
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(1));
        cyc = 1; seq = 0; stall_left = 10; holding = 1'b0; got_done = 1'b0;
        held = '0;
        while (!got_done && cyc <= budget) begin
            cur = {cmd_op, cmd_row, cmd_col, cmd_first, cmd_last};
            if (rmode == RM_RANDOM)
                cmd_ready = ($urandom_range(0, 3) != 0);
            else if (cmd_valid && seq == stall_idx && stall_left > 0) begin
                cmd_ready = 1'b0;
                stall_left--;
            end else
                cmd_ready = 1'b1;
            if (holding) begin
                check("hold_valid", 32'(cmd_valid), 32'(1));
                check("hold_fields", 32'(cur), 32'(held));
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_cmd", 32'(cmd_valid), 32'(0));
                end else begin
                    exp = exp_q.pop_front();
                    check($sformatf("cmd%0d", seq), 32'(cur), 32'(exp));
                end
                last_cmd = cur;
                seq++;
                holding = 1'b0;
                if (abort_after > 0 && seq == abort_after) begin
                    @(posedge clock);
                    #1 reset = 1'b0;
                    #1;
                    check("abort_valid", 32'(cmd_valid), 32'(0));
                    check("abort_busy", 32'(busy), 32'(0));
                    repeat (3) begin
                        @(negedge clock);
                        check("abort_no_done", 32'(done), 32'(0));
                    end
                    return;
                end
            end else begin
                holding = cmd_valid;
                held    = cur;
            end
            if (done) begin
                got_done = 1'b1;
                check("done_error", 32'(error), 32'(exp_err));
                check("queue_empty", 32'(exp_q.size()), 32'(0));
                if (exp_err) check("err_latency", 32'(cyc), 32'(2));
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        if (!got_done) begin
            check("timeout", 32'(done), 32'(1));
        end else begin
            @(negedge clock);
            check("done_pulse", 32'(done), 32'(0));
            check("idle_busy", 32'(busy), 32'(0));
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cmd_ready = 1'b0;
        a_rows = '0; a_cols = '0; b_rows = '0; b_cols = '0;
        last_cmd = '0;
        #12;
        check("rst_valid", 32'(cmd_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_fields", 32'({cmd_op, cmd_row, cmd_col, cmd_first, cmd_last}), 32'(0));
        @(negedge clock);
        reset = 1'b1;

        // Single tile, always ready.
        run_job(4, 4, 4, 4, RM_READY, -1, 0, 100);
        check("t1_last", 32'(last_cmd), 32'(cmd_t'{CMD_STORE, 8'd0, 8'd0, 1'b0, 1'b0}));
`ifdef TILE_SCHED_PERF_EN
        check("t1_perf_busy", perf_busy_cycles, 32'd6);
        check("t1_perf_stall", perf_stall_cycles, 32'd0);
`endif

        // Two i tiles, two k tiles.
        run_job(5, 6, 6, 3, RM_READY, -1, 0, 100);
        check("t2_last", 32'(last_cmd), 32'(cmd_t'{CMD_STORE, 8'd4, 8'd0, 1'b0, 1'b0}));

        // Dimension errors: inner mismatch, then a zero dimension.
        run_job(4, 4, 5, 4, RM_READY, -1, 0, 20);
        run_job(0, 4, 4, 4, RM_READY, -1, 0, 20);

        // Ten cycles of backpressure on the LOAD_B of the second tile.
        run_job(5, 6, 6, 3, RM_READY, 8, 0, 100);
`ifdef TILE_SCHED_PERF_EN
        check("bp_perf_stall", perf_stall_cycles, 32'd10);
        check("bp_perf_busy", perf_busy_cycles, 32'd26);
`endif

        // Reset after the fifth transfer, then a clean rerun.
        run_job(5, 6, 6, 3, RM_READY, -1, 5, 100);
        @(negedge clock);
        reset = 1'b1;
        run_job(5, 6, 6, 3, RM_READY, -1, 0, 100);
        check("rerun_last", 32'(last_cmd), 32'(cmd_t'{CMD_STORE, 8'd4, 8'd0, 1'b0, 1'b0}));

        // Deep k loop reaching the maximum k offset.
        run_job(4, 255, 255, 4, RM_RANDOM, -1, 0, 2000);
        check("deepk_last", 32'(last_cmd), 32'(cmd_t'{CMD_STORE, 8'd0, 8'd0, 1'b0, 1'b0}));

        // Full 64x64 tile grid with random backpressure; last STORE at (252,252).
        run_job(255, 4, 4, 255, RM_RANDOM, -1, 0, 60000);
        check("grid_last", 32'(last_cmd), 32'(cmd_t'{CMD_STORE, 8'd252, 8'd252, 1'b0, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
